// File: rtl/usr_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// usr_pkg
// Mode codes, FSM state encoding and a mode-class helper for univ_shift_reg.
// Revision: 1.0 - initial release
// ----------------------------------------------------------------------------
package usr_pkg;

  localparam logic [2:0] MODE_HOLD  = 3'b000;
  localparam logic [2:0] MODE_SHL   = 3'b001;
  localparam logic [2:0] MODE_SHR   = 3'b010;
  localparam logic [2:0] MODE_ROL   = 3'b011;
  localparam logic [2:0] MODE_ROR   = 3'b100;
  localparam logic [2:0] MODE_ASR   = 3'b101;
  localparam logic [2:0] MODE_LOAD  = 3'b110;
  localparam logic [2:0] MODE_CLEAR = 3'b111;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_t;

  // Shift/rotate modes honour the amount field; the rest are single-shot.
  function automatic logic is_shift_mode(input logic [2:0] m);
    return (m >= MODE_SHL) && (m <= MODE_ASR);
  endfunction

endpackage
`default_nettype wire

// File: rtl/usr_step.sv
`default_nettype none
// ----------------------------------------------------------------------------
// usr_step
// Combinational single-step next-value function of the universal shifter.
// Revision: 1.0 - initial release
// ----------------------------------------------------------------------------
module usr_step
  import usr_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] q,
  input  logic [2:0]       mode,
  input  logic             sin_lsb,
  input  logic             sin_msb,
  input  logic [WIDTH-1:0] load_data,
  output logic [WIDTH-1:0] q_next
);

  // One step of the selected operation; HOLD keeps the current value.
  always_comb begin
    q_next = q;
    case (mode)
      MODE_HOLD:  q_next = q;
      MODE_SHL:   q_next = {q[WIDTH-2:0], sin_lsb};
      MODE_SHR:   q_next = {sin_msb, q[WIDTH-1:1]};
      MODE_ROL:   q_next = {q[WIDTH-2:0], q[WIDTH-1]};
      MODE_ROR:   q_next = {q[0], q[WIDTH-1:1]};
      MODE_ASR:   q_next = {q[WIDTH-1], q[WIDTH-1:1]};
      MODE_LOAD:  q_next = load_data;
      MODE_CLEAR: q_next = '0;
      default:    q_next = q;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/univ_shift_reg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// univ_shift_reg
// Parametrised universal shift register with multi-step start/busy/done
// command handshake.
// Revision: 1.0 - initial release
// ----------------------------------------------------------------------------
module univ_shift_reg
  import usr_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [2:0]       mode,
  input  logic [CNT_W-1:0] amount,
  input  logic [WIDTH-1:0] load_data,
  input  logic             sin_lsb,
  input  logic             sin_msb,
  output logic [WIDTH-1:0] q,
  output logic             sout_msb,
  output logic             sout_lsb,
  output logic             busy,
  output logic             done
);

  state_t           state, state_nxt;
  logic [2:0]       cmd_mode, cmd_mode_nxt;
  logic [CNT_W-1:0] remaining, remaining_nxt;
  logic [WIDTH-1:0] q_nxt;
  logic             done_nxt;
  logic [2:0]       step_mode;
  logic [WIDTH-1:0] q_step;

  usr_step #(.WIDTH(WIDTH)) u_step (
    .q         (q),
    .mode      (step_mode),
    .sin_lsb   (sin_lsb),
    .sin_msb   (sin_msb),
    .load_data (load_data),
    .q_next    (q_step)
  );

  // State, counter, captured mode, data and done pulse registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      cmd_mode  <= MODE_HOLD;
      remaining <= '0;
      q         <= '0;
      done      <= 1'b0;
    end else begin
      state     <= state_nxt;
      cmd_mode  <= cmd_mode_nxt;
      remaining <= remaining_nxt;
      q         <= q_nxt;
      done      <= done_nxt;
    end
  end

  // Next-state logic: first step happens on the accepting edge, the rest in SHIFT.
  always_comb begin
    state_nxt     = state;
    cmd_mode_nxt  = cmd_mode;
    remaining_nxt = remaining;
    q_nxt         = q;
    done_nxt      = 1'b0;
    step_mode     = cmd_mode;
    case (state)
      ST_IDLE: begin
        step_mode = mode;
        if (start) begin
          done_nxt = 1'b1;
          if (is_shift_mode(mode)) begin
            if (amount != '0) begin
              q_nxt = q_step;
            end
            if (amount > CNT_W'(1)) begin
              remaining_nxt = amount - CNT_W'(1);
              cmd_mode_nxt  = mode;
              state_nxt     = ST_SHIFT;
              done_nxt      = 1'b0;
            end
          end else begin
            q_nxt = q_step;
          end
        end
      end
      ST_SHIFT: begin
        q_nxt         = q_step;
        remaining_nxt = remaining - CNT_W'(1);
        if (remaining == CNT_W'(1)) begin
          state_nxt = ST_IDLE;
          done_nxt  = 1'b1;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Serial outputs and busy flag are direct decodes of register state.
  always_comb begin
    sout_msb = q[WIDTH-1];
    sout_lsb = q[0];
    busy     = (state == ST_SHIFT);
  end

endmodule
`default_nettype wire
